boton_eventos: RTL and testbench

Press-event decoder that sits downstream of the debounced button chain: it consumes one clean, synchronous, active-high button level and turns it into single-cycle event pulses (press, short release, long press, auto-repeat) plus a held level for the game-logic FSM. It is the consuming end of the button path. The debouncer guarantees a stable level, and this block assigns meaning to that level over time, so UI logic never counts cycles itself.

---
 rtl/boton_pkg.sv | 39 +++
 rtl/boton_eventos_contador_umbral.sv | 45 ++++
 rtl/boton_eventos.sv | 168 ++++++++++++++++
 tb/tb_boton_eventos.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/boton_pkg.sv
// ---------------------------------------------------------------------------
// boton_pkg
// Shared definitions for the button event path: the press-decoder state
// encoding and the default timing constants.
// The debouncer instantiation sites reuse these defaults, so a board-level
// retiming is a single edit here.
// Contents:
//   estado_t            - decoder FSM states (IDLE, PRESSED, LONG_HELD)
//   LONG_TIME_DEF       - cycles to a long press (1 s at 50 MHz)
//   REPEAT_TIME_DEF     - cycles between auto-repeats (250 ms at 50 MHz)
//   CNT_W_DEF           - counter width that covers both defaults
//   cnt_w_suficiente()  - true when a counter width can hold both limits
// ---------------------------------------------------------------------------
package boton_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } estado_t;

  localparam int unsigned LONG_TIME_DEF   = 50_000_000;
  localparam int unsigned REPEAT_TIME_DEF = 12_500_000;
  localparam int          CNT_W_DEF       = 26;

  // The counter only ever counts up to limit-1.
  // Requiring 2^cnt_w to exceed the larger limit is therefore enough to
  // guarantee it never wraps.
  function automatic bit cnt_w_suficiente(input int cnt_w,
                                          input longint unsigned long_t,
                                          input longint unsigned rep_t);
    longint unsigned mayor;
    longint unsigned capacidad;
    mayor     = (long_t > rep_t) ? long_t : rep_t;
    capacidad = (cnt_w >= 63) ? 64'hFFFF_FFFF_FFFF_FFFF : (64'd1 << cnt_w);
    return (cnt_w > 0) && (capacidad > mayor);
  endfunction

endpackage

// File: rtl/boton_eventos_contador_umbral.sv
// ---------------------------------------------------------------------------
// contador_umbral
// Up-counter with synchronous clear and a terminal-count compare against a
// run-time limit.
// The press decoder owns no counter of its own. Instead, it drives clear
// and limit here, and uses terminal to decide when a threshold is reached.
// Ports:
//   clk       in  system clock
//   rst       in  synchronous active-high reset (count <- 0)
//   clear     in  synchronous clear (count <- 0), has priority over enable
//   enable    in  advance the count by one
//   limit     in  [CNT_W-1:0] value at which terminal asserts
//   terminal  out high while the current count equals limit
// ---------------------------------------------------------------------------
module contador_umbral #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             terminal
);

  logic [CNT_W-1:0] cnt;

  // Count register.
  // Reset and clear both return to zero.
  // The decoder clears before the count can reach the top of its range, so
  // no wrap handling is needed.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Terminal is combinational on the registered count.
  // This lets the decoder act on the same edge where the count sits at the
  // limit.
  assign terminal = (cnt == limit);

endmodule

// File: rtl/boton_eventos.sv
// ---------------------------------------------------------------------------
// boton_eventos
// Press-event decoder at the end of the button chain.
// It turns a clean, synchronous button level into single-cycle events for
// the UI logic: press, short release, long press and auto-repeat. It also
// provides a held level while a press is in progress.
// Parameters:
//   LONG_TIME    cycles high after the press before pulse_long (>= 2)
//   REPEAT_TIME  cycles between pulse_repeat while long-held (0 = off, else >= 2)
//   CNT_W        counter width, 2^CNT_W > max(LONG_TIME, REPEAT_TIME)
// Ports:
//   clk           in  system clock
//   rst           in  synchronous active-high reset
//   btn_in        in  debounced level, 1 = pressed, already synchronous to clk
//   pulse_press   out one-cycle pulse on a new press
//   pulse_short   out one-cycle pulse on a release before the long threshold
//   pulse_long    out one-cycle pulse when the long threshold is reached
//   pulse_repeat  out one-cycle pulse every REPEAT_TIME cycles while long-held
//   held          out level, high while a press is being tracked
// All outputs are registered.
// btn_in is sampled directly, so it must never come from an asynchronous
// source.
// ---------------------------------------------------------------------------
module boton_eventos
  import boton_pkg::*;
#(
  parameter int unsigned LONG_TIME   = LONG_TIME_DEF,
  parameter int unsigned REPEAT_TIME = REPEAT_TIME_DEF,
  parameter int          CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulse_press,
  output logic pulse_short,
  output logic pulse_long,
  output logic pulse_repeat,
  output logic held
);

  // Reject parameter sets that would break the timing guarantees.
  // A zero-length long threshold, a one-cycle repeat period, or a counter
  // too narrow to reach its limit would all misbehave silently, so they are
  // refused at elaboration.
  if (LONG_TIME < 2) begin : g_chk_long
    $error("boton_eventos: LONG_TIME must be at least 2");
  end
  if (REPEAT_TIME == 1) begin : g_chk_repeat
    $error("boton_eventos: REPEAT_TIME must be 0 or at least 2");
  end
  if (!cnt_w_suficiente(CNT_W, longint'(LONG_TIME), longint'(REPEAT_TIME))) begin : g_chk_width
    $error("boton_eventos: CNT_W too narrow for LONG_TIME/REPEAT_TIME");
  end

  localparam logic [CNT_W-1:0] LIM_LONG = CNT_W'(LONG_TIME - 1);
  localparam logic [CNT_W-1:0] LIM_REP  =
    (REPEAT_TIME == 0) ? '0 : CNT_W'(REPEAT_TIME - 1);

  estado_t          state;
  estado_t          state_next;
  logic             press_next;
  logic             short_next;
  logic             long_next;
  logic             repeat_next;
  logic             held_next;
  logic             cnt_clear;
  logic             cnt_enable;
  logic [CNT_W-1:0] cnt_limit;
  logic             cnt_terminal;

  // The count is shared between the long-press wait and the repeat period.
  // Only the limit changes with the state.
  assign cnt_limit = (state == LONG_HELD) ? LIM_REP : LIM_LONG;

  contador_umbral #(
    .CNT_W (CNT_W)
  ) u_contador (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .limit    (cnt_limit),
    .terminal (cnt_terminal)
  );

  // Next state, next outputs and counter control.
  // The counter is cleared by default, so every transition and every idle
  // cycle restarts it from zero.
  // It only advances while waiting inside PRESSED or LONG_HELD.
  // Release is tested before the threshold, so a release on the threshold
  // edge gives pulse_short and never pulse_long.
  always_comb begin
    state_next  = state;
    press_next  = 1'b0;
    short_next  = 1'b0;
    long_next   = 1'b0;
    repeat_next = 1'b0;
    cnt_clear   = 1'b1;
    cnt_enable  = 1'b0;

    unique case (state)
      IDLE: begin
        if (btn_in) begin
          state_next = PRESSED;
          press_next = 1'b1;
        end
      end

      PRESSED: begin
        if (!btn_in) begin
          state_next = IDLE;
          short_next = 1'b1;
        end else if (cnt_terminal) begin
          state_next = LONG_HELD;
          long_next  = 1'b1;
        end else begin
          cnt_clear  = 1'b0;
          cnt_enable = 1'b1;
        end
      end

      LONG_HELD: begin
        // A long press ends silently.
        // The long event was already reported, so there is no short
        // release here.
        if (!btn_in) begin
          state_next = IDLE;
        end else if (REPEAT_TIME == 0) begin
          cnt_clear = 1'b1;
        end else if (cnt_terminal) begin
          repeat_next = 1'b1;
        end else begin
          cnt_clear  = 1'b0;
          cnt_enable = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    held_next = (state_next != IDLE);
  end

  // State and output registers.
  // Reset overrides any transition decided in the same cycle.
  // If the button is still down afterwards, the next edge sees it from IDLE
  // and issues a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pulse_press  <= 1'b0;
      pulse_short  <= 1'b0;
      pulse_long   <= 1'b0;
      pulse_repeat <= 1'b0;
      held         <= 1'b0;
    end else begin
      state        <= state_next;
      pulse_press  <= press_next;
      pulse_short  <= short_next;
      pulse_long   <= long_next;
      pulse_repeat <= repeat_next;
      held         <= held_next;
    end
  end

endmodule

// File: tb/tb_boton_eventos.sv
// ---------------------------------------------------------------------------
// tb_boton_eventos
// Self-checking bench for boton_eventos.
// Two instances share the same stimulus:
//   dut_a  LONG_TIME=8, REPEAT_TIME=4, CNT_W=4
//   dut_b  LONG_TIME=8, REPEAT_TIME=0 (auto-repeat disabled)
// Each driven cycle pushes the expected output vectors for the cycle after
// the next edge. They are popped and compared once that edge has passed.
// Expected vector layout: {press, short, long, repeat, held}.
// ---------------------------------------------------------------------------
module tb_boton_eventos;

  localparam int L = 8;
  localparam int R = 4;

  logic clk;
  logic rst;
  logic btn_in;

  logic a_press, a_short, a_long, a_repeat, a_held;
  logic b_press, b_short, b_long, b_repeat, b_held;

  typedef struct {
    string      tag;
    logic [4:0] exp_a;
    logic [4:0] exp_b;
  } expect_t;

  expect_t sb[$];
  int      checks   = 0;
  int      failures = 0;

  boton_eventos #(
    .LONG_TIME   (L),
    .REPEAT_TIME (R),
    .CNT_W       (4)
  ) dut_a (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .pulse_press  (a_press),
    .pulse_short  (a_short),
    .pulse_long   (a_long),
    .pulse_repeat (a_repeat),
    .held         (a_held)
  );

  boton_eventos #(
    .LONG_TIME   (L),
    .REPEAT_TIME (0),
    .CNT_W       (4)
  ) dut_b (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .pulse_press  (b_press),
    .pulse_short  (b_short),
    .pulse_long   (b_long),
    .pulse_repeat (b_repeat),
    .held         (b_held)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for a clean press of h sampled-high edges starting
  // from IDLE.
  // i counts edges from the first edge that sees the button high. The
  // vector is what should be visible just after edge i.
  function automatic logic [4:0] expVec(input int i, input int h, input int r);
    logic p, s, lg, rp, hd;
    p  = (i == 0) && (h > 0);
    s  = (h > 0) && (h <= L) && (i == h);
    lg = (h > L) && (i == L);
    rp = (r != 0) && (i > L) && (i < h) && (((i - L) % r) == 0);
    hd = (i < h);
    return {p, s, lg, rp, hd};
  endfunction

  // Pop the oldest expectation and compare both instances against it.
  task automatic checkOutput();
    expect_t    e;
    logic [4:0] obs_a;
    logic [4:0] obs_b;
    obs_a = {a_press, a_short, a_long, a_repeat, a_held};
    obs_b = {b_press, b_short, b_long, b_repeat, b_held};
    checks++;
    assert (sb.size() > 0) else begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0d expected=>0", sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (obs_a === e.exp_a) else begin
        failures++;
        $error("FAIL %s dut_a observed=%b expected=%b", e.tag, obs_a, e.exp_a);
      end
      checks++;
      assert (obs_b === e.exp_b) else begin
        failures++;
        $error("FAIL %s dut_b observed=%b expected=%b", e.tag, obs_b, e.exp_b);
      end
    end
  endtask

  // Drive one cycle away from the active edge and record what must follow.
  // Then let the edge pass and check just after it.
  task automatic applyStimulus(input logic b, input logic r, input string tag,
                               input logic [4:0] ea, input logic [4:0] eb);
    expect_t e;
    @(negedge clk);
    btn_in  = b;
    rst     = r;
    e.tag   = tag;
    e.exp_a = ea;
    e.exp_b = eb;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Hold the button for h edges, then leave it released for gap edges.
  task automatic runPress(input int h, input int gap, input string tag);
    for (int i = 0; i < h + gap; i++) begin
      applyStimulus((i < h), 1'b0, $sformatf("%s_%0d", tag, i),
                    expVec(i, h, R), expVec(i, h, 0));
    end
  endtask

  initial begin
    btn_in = 1'b0;
    rst    = 1'b1;

    // Reset state, including a reset edge that sees the button pressed.
    applyStimulus(1'b0, 1'b1, "reset_0", 5'b0, 5'b0);
    applyStimulus(1'b0, 1'b1, "reset_1", 5'b0, 5'b0);
    applyStimulus(1'b1, 1'b1, "reset_btn", 5'b0, 5'b0);
    applyStimulus(1'b0, 1'b0, "idle_0", 5'b0, 5'b0);
    applyStimulus(1'b0, 1'b0, "idle_1", 5'b0, 5'b0);

    // Short tap of three cycles.
    runPress(3, 3, "tap");

    // Long hold: long at +8, repeats at +12 and +16, silent release at +20.
    runPress(20, 3, "long");

    // Release lands on the threshold edge, so only a short release is seen.
    runPress(8, 3, "boundary");

    // One more cycle of hold crosses the threshold.
    runPress(9, 3, "just_long");

    // Long hold to exercise repeat-disabled behaviour on dut_b.
    runPress(30, 2, "norepeat");

    // Reset mid-hold with the button still down.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, $sformatf("midrst_%0d", i),
                    expVec(i, 40, R), expVec(i, 40, 0));
    end
    applyStimulus(1'b1, 1'b1, "midrst_rst", 5'b0, 5'b0);
    runPress(12, 3, "after_rst");

    // Back-to-back: one released cycle between presses.
    runPress(3, 1, "b2b_a");
    runPress(10, 3, "b2b_b");

    $display("[TB] scoreboard entries left: %0d", sb.size());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
